// File: rtl/load_store_unit.sv
// Load/store front end: validates funct3/alignment, runs one data_bus cycle, returns an extended response.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned half/word accesses into byte cycles.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | single aligned bus cycle
// SPLIT  | byte-by-byte bus cycles for a misaligned access
// RESP   | response held until writeback takes it
module load_store_unit #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [RD_W-1:0] req_rd,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [RD_W-1:0] resp_rd,
   output logic            resp_exc,
   output logic            resp_misaligned,
   output logic            bus_rw,
   output logic [1:0]      bus_len,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_write,
   input  logic [XLEN-1:0] bus_read,
   input  logic            bus_exception
);

   typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

   state_t     state;
   logic       r_store;
   logic [2:0] r_funct3;
   logic       illegal;
   logic       misaligned;

   always_comb begin
      illegal    = req_store ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                             : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
      misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
   end

   function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
      case (f3)
         3'b000:  return {{(XLEN-8){d[7]}}, d[7:0]};
         3'b001:  return {{(XLEN-16){d[15]}}, d[15:0]};
         3'b100:  return {{(XLEN-8){1'b0}}, d[7:0]};
         3'b101:  return {{(XLEN-16){1'b0}}, d[15:0]};
         default: return d;
      endcase
   endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [1:0]      cnt;
   logic [1:0]      cnt_nx;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] hold;
   logic [XLEN-1:0] hold_nx;
   logic            last;

   // hold_nx includes the byte arriving this cycle so the final byte can be extended directly
   always_comb begin
      cnt_nx                      = cnt + 2'd1;
      hold_nx                     = hold;
      hold_nx[{cnt, 3'b000} +: 8] = bus_read[7:0];
      last                        = (cnt == ((r_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3));
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_data       <= '0;
         resp_rd         <= '0;
         resp_exc        <= 1'b0;
         resp_misaligned <= 1'b0;
         bus_rw          <= 1'b0;
         bus_len         <= '0;
         bus_addr        <= '0;
         bus_write       <= '0;
         r_store         <= 1'b0;
         r_funct3        <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
         cnt             <= '0;
         r_addr          <= '0;
         r_wdata         <= '0;
         hold            <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  r_store   <= req_store;
                  r_funct3  <= req_funct3;
                  resp_rd   <= req_rd;
                  if (illegal) begin
                     state           <= RESP;
                     resp_valid      <= 1'b1;
                     resp_exc        <= 1'b1;
                     resp_misaligned <= 1'b0;
                     resp_data       <= '0;
                  end else if (misaligned) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                     state     <= SPLIT;
                     cnt       <= '0;
                     hold      <= '0;
                     r_addr    <= req_addr;
                     r_wdata   <= req_wdata;
                     bus_rw    <= req_store;
                     bus_len   <= '0;
                     bus_addr  <= req_addr;
                     bus_write <= req_store ? {{(XLEN-8){1'b0}}, req_wdata[7:0]} : '0;
`else
                     state           <= RESP;
                     resp_valid      <= 1'b1;
                     resp_exc        <= 1'b1;
                     resp_misaligned <= 1'b1;
                     resp_data       <= '0;
`endif
                  end else begin
                     state     <= ACCESS;
                     bus_rw    <= req_store;
                     bus_len   <= req_funct3[1:0];
                     bus_addr  <= req_addr;
                     bus_write <= req_store ? req_wdata : '0;
                  end
               end
            end
            ACCESS: begin
               state           <= RESP;
               bus_rw          <= 1'b0;
               bus_len         <= '0;
               bus_addr        <= '0;
               bus_write       <= '0;
               resp_valid      <= 1'b1;
               resp_exc        <= bus_exception;
               resp_misaligned <= 1'b0;
               resp_data       <= (bus_exception || r_store) ? '0 : extend(r_funct3, bus_read);
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
               if (bus_exception || last) begin
                  state           <= RESP;
                  bus_rw          <= 1'b0;
                  bus_len         <= '0;
                  bus_addr        <= '0;
                  bus_write       <= '0;
                  resp_valid      <= 1'b1;
                  resp_exc        <= bus_exception;
                  resp_misaligned <= 1'b0;
                  resp_data       <= (bus_exception || r_store) ? '0 : extend(r_funct3, hold_nx);
               end else begin
                  cnt       <= cnt_nx;
                  hold      <= hold_nx;
                  bus_addr  <= r_addr + XLEN'(cnt_nx);
                  bus_write <= r_store ? {{(XLEN-8){1'b0}}, r_wdata[{cnt_nx, 3'b000} +: 8]} : '0;
               end
            end
`endif
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
